// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer responder: bus bit positions, pixel width
// and the bus direction mode.
package fb_pkg;
  localparam int BIT_WRITE  = 7;
  localparam int BIT_RSTPTR = 6;
  localparam int BIT_DOIT   = 5;
  localparam int BIT_ACK    = 4;
  localparam int NIBBLE     = 4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mode_t;
endpackage

// File: rtl/fb_ram.sv
// Single-port framebuffer store, one 4-bit gray pixel per word, one-clock read latency.
module fb_ram
  import fb_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [NIBBLE-1:0] wdata,
  output logic [NIBBLE-1:0] rdata
);
  logic [NIBBLE-1:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/qspi_framebuffer_responder.sv
// Framebuffer end of the 8-bit QSPI-style display bus: accepts nibble writes from the
// host and streams stored pixels back, locked to the host's h_sync and the tapped v_sync.
module qspi_framebuffer_responder
  import fb_pkg::*;
#(
  parameter int H_PIXELS     = 320,
  parameter int V_LINES      = 240,
  parameter int PIXEL_DIV    = 2,
  parameter int LINE_REPEAT  = 2,
  parameter int HSTART_DELAY = 48,
  parameter int VSTART_LINES = 33,
  parameter int ADDR_W       = $clog2(H_PIXELS * V_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        host_out,
  input  logic [7:0]        host_oe,
  input  logic              v_sync_in,
  output logic [7:0]        resp_out,
  output logic [7:0]        resp_oe,
  output logic [ADDR_W-1:0] wr_ptr
);
  localparam int FB_SIZE   = H_PIXELS * V_LINES;
  localparam int VIS_LINES = V_LINES * LINE_REPEAT;
  localparam int LINE_W    = $clog2(VIS_LINES + VSTART_LINES) + 1;
  localparam int TMR_W     = $clog2(HSTART_DELAY + 1);
  localparam int COL_W     = $clog2(H_PIXELS + 1);
  localparam int PH_W      = $clog2(PIXEL_DIV + 1);
  localparam int REP_W     = $clog2(LINE_REPEAT + 1);

  mode_t             mode_reg;
  logic              hs_d_reg, doit_d_reg, vs_d_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic              ack_reg;
  logic [LINE_W-1:0] line_reg;
  logic [REP_W-1:0]  rep_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [TMR_W-1:0]  tmr_reg;
  logic              run_reg, act_reg, pix_vld_reg;
  logic [COL_W-1:0]  col_reg;
  logic [PH_W-1:0]   ph_reg;

  logic              write_mode, rst_ptr, doit_rise, hs_rise, hs_fall, vs_fall;
  logic              line_vis, wr_en;
  logic [ADDR_W-1:0] wr_addr, ram_addr;
  logic [NIBBLE-1:0] ram_rdata;
  logic              unused_bits;

  assign write_mode  = (mode_reg == WRITE);
  assign rst_ptr     = host_out[BIT_RSTPTR];
  assign doit_rise   = host_out[BIT_DOIT] & ~doit_d_reg;
  assign hs_rise     = rst_ptr & ~hs_d_reg;
  assign hs_fall     = ~rst_ptr & hs_d_reg;
  assign vs_fall     = ~v_sync_in & vs_d_reg;
  assign line_vis    = (line_reg < LINE_W'(VIS_LINES));
  assign unused_bits = ^{host_out[4], host_oe[7:5]};

  // reset_ptr coinciding with a doit edge writes address 0, not the old pointer
  assign wr_addr  = rst_ptr ? '0 : wr_ptr_reg;
  assign wr_en    = write_mode & doit_rise & ~rst;
  assign ram_addr = write_mode ? wr_addr : row_base_reg + ADDR_W'(col_reg);

  fb_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .addr  (ram_addr),
    .wdata (host_out[NIBBLE-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg   <= READ;
      hs_d_reg   <= 1'b0;
      doit_d_reg <= 1'b0;
      vs_d_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      ack_reg    <= 1'b0;
    end else begin
      mode_reg   <= host_out[BIT_WRITE] ? WRITE : READ;
      hs_d_reg   <= rst_ptr;
      doit_d_reg <= host_out[BIT_DOIT];
      vs_d_reg   <= v_sync_in;
      ack_reg    <= write_mode & doit_rise;
      if (write_mode && doit_rise) begin
        wr_ptr_reg <= (wr_addr == ADDR_W'(FB_SIZE - 1)) ? '0 : wr_addr + 1'b1;
      end else if (write_mode && rst_ptr) begin
        wr_ptr_reg <= '0;
      end
    end
  end

  // Line tracking; the row base advances by one stored row every LINE_REPEAT visible lines
  always_ff @(posedge clk) begin
    if (rst) begin
      line_reg     <= '0;
      rep_reg      <= '0;
      row_base_reg <= '0;
    end else if (vs_fall) begin
      line_reg     <= LINE_W'(0) - LINE_W'(VSTART_LINES);
      rep_reg      <= '0;
      row_base_reg <= '0;
    end else if (!write_mode && hs_rise) begin
      line_reg <= line_reg + 1'b1;
      if (line_vis) begin
        if (rep_reg == REP_W'(LINE_REPEAT - 1)) begin
          rep_reg      <= '0;
          row_base_reg <= row_base_reg + ADDR_W'(H_PIXELS);
        end else begin
          rep_reg <= rep_reg + 1'b1;
        end
      end
    end
  end

  // Column timing: the address goes active one clock before its pixel is due on the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_reg     <= '0;
      run_reg     <= 1'b0;
      act_reg     <= 1'b0;
      col_reg     <= '0;
      ph_reg      <= '0;
      pix_vld_reg <= 1'b0;
    end else begin
      pix_vld_reg <= act_reg & line_vis & ~write_mode;
      if (write_mode) begin
        run_reg <= 1'b0;
        act_reg <= 1'b0;
      end else if (hs_fall) begin
        run_reg <= 1'b1;
        act_reg <= 1'b0;
        tmr_reg <= '0;
      end else if (run_reg) begin
        if (tmr_reg == TMR_W'(HSTART_DELAY - 2)) begin
          run_reg <= 1'b0;
          act_reg <= 1'b1;
          col_reg <= '0;
          ph_reg  <= '0;
        end else begin
          tmr_reg <= tmr_reg + 1'b1;
        end
      end else if (act_reg) begin
        if (ph_reg == PH_W'(PIXEL_DIV - 1)) begin
          ph_reg <= '0;
          if (col_reg == COL_W'(H_PIXELS - 1)) begin
            act_reg <= 1'b0;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end else begin
          ph_reg <= ph_reg + 1'b1;
        end
      end
    end
  end

  // Low-nibble drive only when reading and the host has released those pins
  always_comb begin
    resp_oe = 8'h00;
    if (!rst) begin
      resp_oe[BIT_ACK] = ~host_oe[BIT_ACK];
      if (!write_mode && host_oe[NIBBLE-1:0] == '0) begin
        resp_oe[NIBBLE-1:0] = '1;
      end
    end
  end

  assign resp_out = {3'b000, ack_reg, pix_vld_reg ? ram_rdata : NIBBLE'(0)};
  assign wr_ptr   = wr_ptr_reg;
endmodule

// File: tb/tb_qspi_framebuffer_responder.sv
// Bench for qspi_framebuffer_responder on a reduced 20x4 framebuffer so the write
// pointer wrap and whole frames stay short; timing parameters keep their real values.
module tb_qspi_framebuffer_responder;
  localparam int H   = 20;
  localparam int V   = 4;
  localparam int LR  = 2;
  localparam int PD  = 2;
  localparam int HSD = 48;
  localparam int VSL = 33;
  localparam int FB  = H * V;
  localparam int VIS = V * LR;
  localparam int AW  = $clog2(FB);
  localparam int NK  = HSD + H * PD + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    host_out = 8'h00;
  logic [7:0]    host_oe = 8'hE0;
  logic          v_sync_in = 1'b1;
  logic [7:0]    resp_out, resp_oe;
  logic [AW-1:0] wr_ptr;

  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_q[$];
  string      tag_q[$];
  logic [3:0] mdl [0:FB-1];
  int         mptr = 0;

  qspi_framebuffer_responder #(
    .H_PIXELS(H), .V_LINES(V), .PIXEL_DIV(PD), .LINE_REPEAT(LR),
    .HSTART_DELAY(HSD), .VSTART_LINES(VSL)
  ) dut (
    .clk(clk), .rst(rst), .host_out(host_out), .host_oe(host_oe),
    .v_sync_in(v_sync_in), .resp_out(resp_out), .resp_oe(resp_oe), .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input int got);
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", got, -1);
    end else begin
      check_eq(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] nib, input bit rp);
    int addr;
    addr = rp ? 0 : mptr;
    host_out = {1'b1, rp, 1'b1, 1'b0, nib};
    mdl[addr] = nib;
    mptr = (addr == FB - 1) ? 0 : addr + 1;
    push_exp("ack", 1);
    push_exp("wr_ptr", mptr);
    push_exp("oe_lo_write", 0);
    tick;
    pop_check(resp_out[4]);
    pop_check(wr_ptr);
    pop_check(resp_oe[3:0]);
    host_out = 8'h80;
    push_exp("ack_off", 0);
    tick;
    pop_check(resp_out[4]);
    $display("write addr=%0d nib=%0h rp=%0d wr_ptr=%0d", addr, nib, rp, wr_ptr);
  endtask

  task automatic hs_pulse;
    host_out[6] = 1'b1;
    tick;
    host_out[6] = 1'b0;
    tick;
  endtask

  task automatic display_line(input int li);
    bit vis;
    int e;
    host_out[6] = 1'b1;
    tick;
    host_out[6] = 1'b0;
    vis = (li >= 0) && (li < VIS);
    for (int k = 0; k < NK; k++) begin
      e = 0;
      if (vis && k >= HSD && k < HSD + H * PD) e = mdl[(li / LR) * H + (k - HSD) / PD];
      push_exp($sformatf("pix_l%0d_k%0d", li, k), e);
    end
    for (int k = 0; k < NK; k++) begin
      tick;
      pop_check(resp_out[3:0]);
      if (k == 0) check_eq("read_oe", resp_oe, 8'h1F);
    end
    $display("line %0d displayed row %0d", li, vis ? li / LR : -1);
  endtask

  task automatic run_frame(input int nlines);
    v_sync_in = 1'b0;
    tick;
    v_sync_in = 1'b1;
    tick;
    repeat (VSL - 2) hs_pulse;
    display_line(-1);
    for (int li = 0; li < nlines; li++) display_line(li);
  endtask

  initial begin
    // reset state, then READ with the low nibble released by the host
    rst = 1'b1;
    repeat (3) tick;
    check_eq("rst_resp_out", resp_out, 0);
    check_eq("rst_resp_oe", resp_oe, 0);
    check_eq("rst_wr_ptr", wr_ptr, 0);
    rst = 1'b0;
    tick;
    check_eq("read_oe_after_rst", resp_oe, 8'h1F);
    $display("reset done resp_oe=%0h", resp_oe);

    // WRITE: nibble drive drops even though the host is not driving it
    host_out = 8'h80;
    tick;
    tick;
    check_eq("write_oe_lo_released", resp_oe[3:0], 0);
    host_oe = 8'hEF;
    host_out = 8'hC0;
    tick;
    mptr = 0;
    check_eq("rstptr_wr_ptr", wr_ptr, 0);
    host_out = 8'h80;
    tick;
    for (int i = 0; i < FB; i++) do_write(i < 4 ? 4'(i + 1) : 4'((i * 7 + 3) % 16), 1'b0);
    check_eq("wrap_wr_ptr", wr_ptr, 0);

    // full frame read back including the line after the last visible one
    host_out = 8'h00;
    host_oe = 8'hE0;
    tick;
    tick;
    run_frame(VIS + 1);

    // reset_ptr alone and together with a doit edge
    host_out = 8'h80;
    host_oe = 8'hEF;
    tick;
    tick;
    do_write(4'h5, 1'b0);
    do_write(4'h6, 1'b0);
    host_out = 8'hC0;
    tick;
    mptr = 0;
    check_eq("rstptr_alone", wr_ptr, 0);
    host_out = 8'h80;
    tick;
    do_write(4'h7, 1'b0);
    do_write(4'h8, 1'b0);
    do_write(4'h9, 1'b1);

    // doit held high: one write, one ack
    mdl[mptr] = 4'hC;
    host_out = {4'b1010, 4'hC};
    mptr = mptr + 1;
    for (int k = 0; k < 10; k++) begin
      push_exp($sformatf("held_ack_%0d", k), k == 0 ? 1 : 0);
      push_exp($sformatf("held_wr_ptr_%0d", k), mptr);
    end
    for (int k = 0; k < 10; k++) begin
      tick;
      pop_check(resp_out[4]);
      pop_check(wr_ptr);
    end
    host_out = 8'h80;
    tick;
    $display("held doit done wr_ptr=%0d", wr_ptr);

    // doit and reset_ptr ignored in READ
    host_out = 8'h00;
    tick;
    tick;
    for (int p = 0; p < 3; p++) begin
      host_out = {4'b0110, ~mdl[mptr]};
      tick;
      check_eq("read_doit_ack", resp_out[4], 0);
      check_eq("read_doit_wr_ptr", wr_ptr, mptr);
      host_out = 8'h00;
      tick;
      check_eq("read_doit_wr_ptr_after", wr_ptr, mptr);
      $display("read-mode doit pulse %0d wr_ptr=%0d", p, wr_ptr);
    end

    // reset lands on the doit edge: write dropped, no ack, pointer cleared
    host_out = 8'h80;
    host_oe = 8'hEF;
    tick;
    tick;
    do_write(4'hD, 1'b0);
    host_out = {4'b1010, ~mdl[mptr]};
    rst = 1'b1;
    mptr = 0;
    push_exp("rst_write_ack", 0);
    push_exp("rst_write_wr_ptr", 0);
    tick;
    pop_check(resp_out[4]);
    pop_check(wr_ptr);
    rst = 1'b0;
    host_out = 8'h00;
    host_oe = 8'hE0;
    tick;
    check_eq("post_rst_ack", resp_out[4], 0);
    check_eq("post_rst_wr_ptr", wr_ptr, 0);
    $display("reset during write done");
    tick;
    run_frame(4);

    check_eq("sb_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
